ball_renderer: RTL and testbench

//  Consumer side of the ball position interface. Generates 640x480@60 VGA

---
 rtl/ball_renderer.sv | 108 ++++++++++
 tb/tb_ball_renderer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ball_renderer.sv
// VGA timing generator and ball rasteriser. It snapshots the ball position once per frame
// and draws the ball with one registered output stage.
module ball_renderer #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter logic [11:0] BALL_RGB = 12'hFFF,
  parameter logic [11:0] BG_RGB   = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  ball_x,
  input  logic [8:0]  ball_y,
  input  logic [5:0]  ball_w,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        active,
  output logic        frame_tick
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Sums are 11 bits wide so a ball near the right/bottom edge never wraps to 0.
  function automatic logic hit_test(input logic [9:0] h, input logic [9:0] v,
                                    input logic [9:0] lx, input logic [8:0] ly,
                                    input logic [5:0] lw);
    logic [10:0] x_end;
    logic [10:0] y_end;
    x_end = {1'b0, lx} + {5'b0, lw};
    y_end = {2'b0, ly} + {5'b0, lw};
    return ({1'b0, h} >= {1'b0, lx}) && ({1'b0, h} < x_end) &&
           ({1'b0, v} >= {2'b0, ly}) && ({1'b0, v} < y_end);
  endfunction

  logic [9:0]  r_hcnt_p0;
  logic [9:0]  r_vcnt_p0;
  logic [9:0]  r_lx;
  logic [8:0]  r_ly;
  logic [5:0]  r_lw;
  logic        r_hsync_p1;
  logic        r_vsync_p1;
  logic        r_active_p1;
  logic [11:0] r_rgb_p1;
  logic        r_tick_p1;

  logic w_active;
  logic w_hit;
  logic w_snap;

  assign w_active = (r_hcnt_p0 < H_VIS) && (r_vcnt_p0 < V_VIS);
  assign w_hit    = hit_test(r_hcnt_p0, r_vcnt_p0, r_lx, r_ly, r_lw);
  assign w_snap   = (r_hcnt_p0 == H_LAST) && (r_vcnt_p0 == V_VIS - 10'd1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hcnt_p0   <= '0;
      r_vcnt_p0   <= '0;
      r_lx        <= '0;
      r_ly        <= '0;
      r_lw        <= '0;
      r_hsync_p1  <= 1'b1;
      r_vsync_p1  <= 1'b1;
      r_active_p1 <= 1'b0;
      r_rgb_p1    <= '0;
      r_tick_p1   <= 1'b0;
    end else begin
      // p0: raster position
      if (r_hcnt_p0 == H_LAST) begin
        r_hcnt_p0 <= '0;
        r_vcnt_p0 <= (r_vcnt_p0 == V_LAST) ? 10'd0 : r_vcnt_p0 + 10'd1;
      end else begin
        r_hcnt_p0 <= r_hcnt_p0 + 10'd1;
      end
      // Snapshot on the last pixel before vertical blanking.
      if (w_snap) begin
        r_lx <= ball_x;
        r_ly <= ball_y;
        r_lw <= ball_w;
      end
      // p1: registered outputs for the pixel evaluated at p0
      r_hsync_p1  <= !((r_hcnt_p0 >= HS_FIRST) && (r_hcnt_p0 <= HS_LAST));
      r_vsync_p1  <= !((r_vcnt_p0 >= VS_FIRST) && (r_vcnt_p0 <= VS_LAST));
      r_active_p1 <= w_active;
      r_rgb_p1    <= w_active ? (w_hit ? BALL_RGB : BG_RGB) : 12'h000;
      r_tick_p1   <= w_snap;
    end
  end

  assign hsync      = r_hsync_p1;
  assign vsync      = r_vsync_p1;
  assign active     = r_active_p1;
  assign rgb        = r_rgb_p1;
  assign frame_tick = r_tick_p1;

endmodule

// File: tb/tb_ball_renderer.sv
// Bench for ball_renderer on a reduced raster (80x55 total, 64x48 visible).
// An arithmetic pixel-index model checks every cycle, and per-frame statistics are pinned to literals.
module tb_ball_renderer;

  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 48, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  ball_x;
  logic [8:0]  ball_y;
  logic [5:0]  ball_w;
  logic        hsync, vsync, active, frame_tick;
  logic [11:0] rgb;

  ball_renderer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .BALL_RGB(12'hFFF), .BG_RGB(12'h000)
  ) dut (
    .clk(clk), .reset(reset), .ball_x(ball_x), .ball_y(ball_y), .ball_w(ball_w),
    .hsync(hsync), .vsync(vsync), .rgb(rgb), .active(active), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // n = number of clock edges seen with reset released; pixel index n-1 is on the outputs.
  int n = 0;
  bit started = 0;
  int sx[16], sy[16], sw[16];
  int epoch = 0;

  always @(posedge clk) begin
    started = 1;
    if (!reset) n = 0;
    else begin
      if ((n % HT) == HT - 1 && ((n / HT) % VT) == VA - 1 && (n / FT) < 16) begin
        sx[n / FT] = ball_x;
        sy[n / FT] = ball_y;
        sw[n / FT] = ball_w;
      end
      n = n + 1;
    end
  end

  int fff_cnt[8], fmin[8], fmax[8], act_cnt[8];
  int hs_run = 0, vs_run = 0, first_hs_n = -1, last_tick_n = -1;
  int first_tick_n[2] = '{-1, -1};

  always @(negedge clk) begin
    int p, h, v, f, lx, ly, lw;
    bit e_hs, e_vs, e_act, e_tick, hit;
    int e_rgb;
    if (started) begin
      if (n == 0) begin
        check("reset_hsync", hsync, 1);
        check("reset_vsync", vsync, 1);
        check("reset_rgb", rgb, 0);
        check("reset_active", active, 0);
        check("reset_tick", frame_tick, 0);
        hs_run = 0; vs_run = 0; last_tick_n = -1;
      end else begin
        p = n - 1;
        h = p % HT; v = (p / HT) % VT; f = p / FT;
        if (f > 0 && f <= 16) begin lx = sx[f-1]; ly = sy[f-1]; lw = sw[f-1]; end
        else begin lx = 0; ly = 0; lw = 0; end
        e_hs   = !(h >= HA + HF && h < HA + HF + HS);
        e_vs   = !(v >= VA + VF && v < VA + VF + VS);
        e_act  = (h < HA) && (v < VA);
        hit    = (h >= lx) && (h < lx + lw) && (v >= ly) && (v < ly + lw);
        e_rgb  = e_act ? (hit ? 'hFFF : 0) : 0;
        e_tick = (h == HT - 1) && (v == VA - 1);
        check($sformatf("hsync@%0d", p), hsync, e_hs);
        check($sformatf("vsync@%0d", p), vsync, e_vs);
        check($sformatf("active@%0d", p), active, e_act);
        check($sformatf("rgb@%0d", p), rgb, e_rgb);
        check($sformatf("tick@%0d", p), frame_tick, e_tick);

        if (!hsync) begin
          hs_run++;
          if (first_hs_n < 0) first_hs_n = n;
        end else if (hs_run > 0) begin
          check("hsync_width", hs_run, HS);
          hs_run = 0;
        end
        if (!vsync) vs_run++;
        else if (vs_run > 0) begin
          check("vsync_width", vs_run, VS * HT);
          vs_run = 0;
        end
        if (frame_tick) begin
          if (last_tick_n >= 0) check("tick_spacing", n - last_tick_n, FT);
          else first_tick_n[epoch] = n;
          last_tick_n = n;
        end
        if (epoch == 0 && f < 8) begin
          if (active) act_cnt[f]++;
          if (rgb == 12'hFFF) begin
            fff_cnt[f]++;
            if (h < fmin[f]) fmin[f] = h;
            if (h > fmax[f]) fmax[f] = h;
          end
        end
      end
    end
  end

  task automatic goto(input int target);
    int i;
    i = 0;
    while (n < target && i < 60000) begin
      @(posedge clk); #1;
      i++;
    end
    if (n < target) begin
      errors++;
      checks++;
      $display("FAIL goto_timeout: got %0d expected %0d", n, target);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      fff_cnt[i] = 0; act_cnt[i] = 0; fmin[i] = 1000; fmax[i] = -1;
    end
    ball_x = 10'd31; ball_y = 9'd24; ball_w = 6'd8;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;

    goto(FT + 10 * HT);         ball_x = 10'd40;
    goto(2 * FT + 10 * HT);     ball_w = 6'd0;
    goto(3 * FT + 10 * HT);     ball_x = 10'd60; ball_w = 6'd8;
    goto(5 * FT + 30 * HT);

    check("first_hsync_fall_n", first_hs_n, HA + HF + 1);
    check("frame0_fff", fff_cnt[0], 0);
    check("frame1_fff", fff_cnt[1], 64);
    check("frame1_xmin", fmin[1], 31);
    check("frame1_xmax", fmax[1], 38);
    check("frame1_active", act_cnt[1], HA * VA);
    check("frame2_fff", fff_cnt[2], 64);
    check("frame2_xmin", fmin[2], 40);
    check("frame3_fff_w0", fff_cnt[3], 0);
    check("frame4_fff_edge", fff_cnt[4], 32);
    check("frame4_xmin", fmin[4], 60);
    check("frame4_xmax", fmax[4], 63);
    check("first_tick_n", first_tick_n[0], VA * HT);

    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1 epoch = 1;
    reset = 1'b1;
    goto(FT + 2 * HT);
    @(negedge clk);
    check("tick_after_reset_n", first_tick_n[1], VA * HT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
